// File: rtl/id_decode_buffer.sv
// rtl/id_decode_buffer.sv - decode stage: splits fetched instructions and queues operand bundles for EX
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous discard of every buffered bundle
//   in_valid/in_ready     fetch handshake; in_instr, in_pc carry the instruction
//   rs1_addr/rs2_addr     register-file read addresses (combinational from in_instr)
//   rs1_data/rs2_data     register-file read data, sampled when the bundle is accepted
//   out_valid/out_ready   EX handshake for the head bundle
//   out_*                 decoded fields of the head bundle, all zero while empty

module id_decode_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [63:0] in_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [63:0] rs1_data,
  input  logic [63:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [11:0] out_immed,
  output logic [63:0] out_reg1,
  output logic [63:0] out_reg2,
  output logic [4:0]  out_rd,
  output logic [63:0] out_pc,
  output logic        out_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] immed;
    logic [63:0] reg1;
    logic [63:0] reg2;
    logic [4:0]  rd;
    logic [63:0] pc;
    logic        illegal;
  } bundle_t;

  bundle_t        mem [DEPTH];
  bundle_t        dec;
  bundle_t        head;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;

  assign rs1_addr  = in_instr[19:15];
  assign rs2_addr  = in_instr[24:20];

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Decode of the incoming instruction. Unsupported encodings keep the
  // R-type field split so EX/commit still sees the raw fields of the trap.
  always_comb begin
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_r;
    logic       is_i;
    logic       legal_r;
    logic       legal_i;

    op   = in_instr[6:0];
    f3   = in_instr[14:12];
    f7   = in_instr[31:25];
    is_r = (op == OP_R);
    is_i = (op == OP_I);

    legal_r = ((f3 == 3'b000) && ((f7 == 7'b0000000) || (f7 == 7'b0100000))) ||
              (((f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b100)) && (f7 == 7'b0000000));
    legal_i = (f3 == 3'b000) || (f3 == 3'b100) || (f3 == 3'b110) || (f3 == 3'b111);

    dec         = '0;
    dec.opcode  = op;
    dec.funct3  = f3;
    dec.funct7  = is_i ? 7'd0 : f7;
    dec.immed   = is_i ? in_instr[31:20] : 12'd0;
    // x0 always reads as zero whatever the register file returns
    dec.reg1    = (rs1_addr == 5'd0) ? 64'd0 : rs1_data;
    dec.reg2    = (is_i || (rs2_addr == 5'd0)) ? 64'd0 : rs2_data;
    dec.rd      = in_instr[11:7];
    dec.pc      = in_pc;
    dec.illegal = !((is_r && legal_r) || (is_i && legal_i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: the outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= dec;
  end

  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr];
  end

  assign out_opcode  = head.opcode;
  assign out_funct3  = head.funct3;
  assign out_funct7  = head.funct7;
  assign out_immed   = head.immed;
  assign out_reg1    = head.reg1;
  assign out_reg2    = head.reg2;
  assign out_rd      = head.rd;
  assign out_pc      = head.pc;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_id_decode_buffer.sv
// tb/tb_id_decode_buffer.sv - directed self-checking bench for id_decode_buffer

module tb_id_decode_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [11:0] out_immed;
  logic [63:0] out_reg1;
  logic [63:0] out_reg2;
  logic [4:0]  out_rd;
  logic [63:0] out_pc;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_decode_buffer #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_funct3 (out_funct3),
    .out_funct7 (out_funct7),
    .out_immed  (out_immed),
    .out_reg1   (out_reg1),
    .out_reg2   (out_reg2),
    .out_rd     (out_rd),
    .out_pc     (out_pc),
    .out_illegal(out_illegal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [63:0] r1, input logic [63:0] r2,
                       input logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    rs1_data = r1;
    rs2_data = r2;
    in_pc    = pc;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    rs1_data  = '0;
    rs2_data  = '0;
    out_ready = 1'b0;

    // reset state
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_reg1",      out_reg1,       64'd0);
    rst_n = 1'b1;
    step();

    // ADD x3,x1,x2
    out_ready = 1'b1;
    drive(32'h002081B3, 64'd5, 64'd7, 64'h1000);
    #1;
    check("add_rs1_addr", 64'(rs1_addr), 64'd1);
    check("add_rs2_addr", 64'(rs2_addr), 64'd2);
    step();
    in_valid = 1'b0;
    check("add_valid",   64'(out_valid),   64'd1);
    check("add_opcode",  64'(out_opcode),  64'h33);
    check("add_funct3",  64'(out_funct3),  64'd0);
    check("add_funct7",  64'(out_funct7),  64'd0);
    check("add_reg1",    out_reg1,         64'd5);
    check("add_reg2",    out_reg2,         64'd7);
    check("add_rd",      64'(out_rd),      64'd3);
    check("add_pc",      out_pc,           64'h1000);
    check("add_illegal", 64'(out_illegal), 64'd0);
    step();
    check("add_drained", 64'(out_valid), 64'd0);

    // ADDI x5,x0,-1 : x0 rule, raw immediate, no rs2 operand
    drive(32'hFFF00293, 64'hDEAD, 64'h1234, 64'h1004);
    step();
    in_valid = 1'b0;
    check("addi_reg1",    out_reg1,         64'd0);
    check("addi_immed",   64'(out_immed),   64'hFFF);
    check("addi_reg2",    out_reg2,         64'd0);
    check("addi_funct7",  64'(out_funct7),  64'd0);
    check("addi_illegal", 64'(out_illegal), 64'd0);
    check("addi_opcode",  64'(out_opcode),  64'h13);
    check("addi_rd",      64'(out_rd),      64'd5);
    step();

    // three back-to-back pushes with EX stalled
    out_ready = 1'b0;
    drive(32'h002081B3, 64'd100, 64'd1, 64'h2000);
    step();
    check("bp_ready_1", 64'(in_ready), 64'd1);
    drive(32'h002081B3, 64'd101, 64'd1, 64'h2004);
    step();
    check("bp_ready_2", 64'(in_ready), 64'd0);
    drive(32'h002081B3, 64'd102, 64'd1, 64'h2008);
    step();
    check("bp_held_ready", 64'(in_ready), 64'd0);
    check("bp_head_stable", out_reg1, 64'd100);
    out_ready = 1'b1;
    step();
    check("bp_second", out_reg1, 64'd101);
    step();
    in_valid = 1'b0;
    check("bp_third", out_reg1, 64'd102);
    check("bp_third_pc", out_pc, 64'h2008);
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // count=1 with simultaneous push and pop
    out_ready = 1'b0;
    drive(32'h002081B3, 64'd200, 64'd1, 64'h3000);
    step();
    out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      drive(32'h002081B3, 64'(200 + k), 64'd1, 64'h3000);
      step();
      check("pp_valid", 64'(out_valid), 64'd1);
      check("pp_head",  out_reg1,       64'(200 + k));
      check("pp_ready", 64'(in_ready),  64'd1);
    end
    in_valid = 1'b0;
    step();
    check("pp_empty", 64'(out_valid), 64'd0);

    // flush with full buffer, same-edge accept and pop
    out_ready = 1'b0;
    drive(32'h002081B3, 64'd300, 64'd1, 64'h4000);
    step();
    drive(32'h002081B3, 64'd301, 64'd1, 64'h4004);
    step();
    check("fl_full", 64'(in_ready), 64'd0);
    flush     = 1'b1;
    out_ready = 1'b1;
    drive(32'h002081B3, 64'd302, 64'd1, 64'h4008);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ready", 64'(in_ready),  64'd1);
    check("fl_reg1",  out_reg1,       64'd0);
    step();
    check("fl_still_empty", 64'(out_valid), 64'd0);

    // SUB is legal with funct7=0100000
    drive(32'h402081B3, 64'd9, 64'd4, 64'h5000);
    step();
    in_valid = 1'b0;
    check("sub_illegal", 64'(out_illegal), 64'd0);
    check("sub_funct7",  64'(out_funct7),  64'h20);
    step();

    // SLL (R-type funct3=001) is unsupported but still delivered
    drive(32'h002091B3, 64'd5, 64'd7, 64'h5004);
    step();
    in_valid = 1'b0;
    check("sll_valid",   64'(out_valid),   64'd1);
    check("sll_illegal", 64'(out_illegal), 64'd1);
    check("sll_funct3",  64'(out_funct3),  64'd1);
    check("sll_reg2",    out_reg2,         64'd7);
    step();

    // opcode 0x03: unsupported, R-type field split (no immediate)
    drive(32'h0020B183, 64'd5, 64'd7, 64'h5008);
    step();
    in_valid = 1'b0;
    check("ld_illegal", 64'(out_illegal), 64'd1);
    check("ld_opcode",  64'(out_opcode),  64'h03);
    check("ld_immed",   64'(out_immed),   64'd0);
    check("ld_reg2",    out_reg2,         64'd7);
    step();

    // asynchronous reset mid-burst
    out_ready = 1'b0;
    drive(32'h002081B3, 64'd400, 64'd1, 64'h6000);
    step();
    drive(32'h002081B3, 64'd401, 64'd1, 64'h6004);
    step();
    in_valid = 1'b0;
    check("ar_before", 64'(out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_ready", 64'(in_ready),  64'd1);
    step();
    rst_n = 1'b1;
    step();
    check("ar_after", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_decode_buffer.md
Name: id_decode_buffer

Overview:
- Instruction-decode stage; the producer end of the operand/field interface consumed by the EX-stage ALU.
- Accepts fetched instructions over a valid/ready handshake and splits each into opcode/funct3/funct7/immediate.
- Reads rs1/rs2 from the register file and presents decoded bundles to EX from a DEPTH-entry FIFO, with illegal-instruction flagging and flush.

Parameters:
- DEPTH, 2, number of buffered decoded bundles; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; discards all buffered bundles.
- in_valid  input  1  fetch bundle valid.
- in_ready  output  1  stage can accept; high iff count != DEPTH.
- in_instr  input  32  raw instruction.
- in_pc  input  64  instruction PC.
- rs1_addr  output  5  register-file read address; combinational, equals in_instr[19:15].
- rs2_addr  output  5  register-file read address; combinational, equals in_instr[24:20].
- rs1_data  input  64  register-file read data for rs1_addr, same cycle.
- rs2_data  input  64  register-file read data for rs2_addr, same cycle.
- out_valid  output  1  head bundle valid; high iff count != 0.
- out_ready  input  1  EX accepts head bundle.
- out_opcode  output  7  instr[6:0].
- out_funct3  output  3  instr[14:12].
- out_funct7  output  7  instr[31:25] for R-type, else 0.
- out_immed  output  12  instr[31:20] for I-type, else 0.
- out_reg1  output  64  rs1 operand.
- out_reg2  output  64  rs2 operand for R-type, else 0.
- out_rd  output  5  instr[11:7].
- out_pc  output  64  captured PC.
- out_illegal  output  1  instruction not in the supported set.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count, read pointer and write pointer go to 0.
  - out_valid = 0; in_ready = 1.
  - All payload outputs read 0 while empty.
  - Reset mid-operation drops all bundles; no partial bundle survives.
- Accept: in_valid && in_ready at a rising edge.
  - The decoded bundle is written at the write pointer.
  - Operands are sampled from rs1_data/rs2_data in that same cycle.
- Pop: out_valid && out_ready at a rising edge advances the read pointer.
- Latency: a bundle accepted at edge N is visible on outputs after edge N (out_valid high in the following cycle); no combinational path from in_* to out_*.
- Occupancy:
  - Push and pop in the same edge leaves count unchanged; both pointers advance.
  - count == DEPTH: in_ready = 0; in_valid is ignored and the input must be held by the producer.
  - count == 0: out_ready is ignored.
  - Pointers wrap modulo DEPTH.
- Payload outputs are driven from the head entry; they are stable while out_valid && !out_ready.
- Flush:
  - Sets count and both pointers to 0 at the edge.
  - Overrides a same-edge accept and pop: the incoming bundle is dropped.
  - in_ready is 1 in the next cycle.
- x0 rule: rs1 index 0 gives reg1 = 0, and rs2 index 0 gives reg2 = 0, regardless of rs*_data.
- Decode for opcode 0110011 (R-type):
  - Legal iff {funct3, funct7} is {000,0000000} ADD, {000,0100000} SUB, {111,0} AND, {110,0} OR, or {100,0} XOR.
  - immed = 0.
- Decode for opcode 0010011 (I-type):
  - Legal iff funct3 is 000, 100, 110 or 111.
  - reg2 = 0, funct7 = 0.
  - immed is passed raw (12 bits); sign extension is EX's job.
- Any other opcode or funct combination:
  - out_illegal = 1; fields are extracted as for R-type.
  - The bundle is still queued; EX/commit decides the trap.
- No hazard or forwarding logic in this block: operands are whatever the register file returned at accept time.

Test Plan:
- After reset, present ADD x3,x1,x2 (0x002081B3) with rs1_data=5, rs2_data=7, out_ready=1 -> next cycle out_valid=1, opcode=0x33, funct3=0, funct7=0, reg1=5, reg2=7, rd=3, illegal=0; out_valid=0 the cycle after.
- ADDI x5,x0,-1 (0xFFF00293) with rs1_data=0xDEAD -> reg1=0 (x0 rule), immed=0xFFF, reg2=0, funct7=0, illegal=0.
- out_ready=0 with three back-to-back valid pushes (DEPTH=2) -> in_ready drops after the 2nd accept, the 3rd is held; raise out_ready -> bundles emerge in order 1,2,3, with pointers wrapping.
- count=1, simultaneous push and pop for 6 cycles -> count stays 1, out_valid stays 1, in-order output with no drops or duplicates.
- count=2 plus flush asserted together with in_valid and out_ready -> next cycle out_valid=0 and in_ready=1; neither the flushed nor the incoming bundle ever appears.
- SLL (funct3=001, opcode 0x33) and opcode 0x03 -> out_illegal=1 for both, bundles still delivered; assert rst_n low mid-burst -> out_valid=0 immediately (asynchronously).
